// File: rtl/valve_exec_pkg.sv
// Shared definitions for the valve executor: time-unit encodings, per-unit microsecond
// constants, FSM state type and the tick-period helper.
package valve_exec_pkg;

    localparam logic [2:0] TimeUnit1Us   = 3'b000;
    localparam logic [2:0] TimeUnit1Ms   = 3'b001;
    localparam logic [2:0] TimeUnit10Ms  = 3'b010;
    localparam logic [2:0] TimeUnit100Ms = 3'b011;
    localparam logic [2:0] TimeUnit1S    = 3'b100;

    localparam int unsigned Us1Us   = 1;
    localparam int unsigned Us1Ms   = 1_000;
    localparam int unsigned Us10Ms  = 10_000;
    localparam int unsigned Us100Ms = 100_000;
    localparam int unsigned Us1S    = 1_000_000;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StManual,
        StHalt
    } state_e;

    // Clock cycles per time unit; reserved encodings fall back to 1 us, never below 1 cycle.
    function automatic int unsigned unit_period(input int unsigned clk_hz,
                                                input logic [2:0] tu);
        longint unsigned us;
        longint unsigned cycles;
        case (tu)
            TimeUnit1Ms:   us = 64'(Us1Ms);
            TimeUnit10Ms:  us = 64'(Us10Ms);
            TimeUnit100Ms: us = 64'(Us100Ms);
            TimeUnit1S:    us = 64'(Us1S);
            default:       us = 64'(Us1Us);
        endcase
        cycles = (64'(clk_hz) * us) / 64'd1_000_000;
        if (cycles == 64'd0) begin
            cycles = 64'd1;
        end
        return cycles[31:0];
    endfunction

endpackage

// File: rtl/valve_exec_unit_tick_gen.sv
// Prescaler producing a one-cycle tick every time-unit period; restart zeroes the phase.
module unit_tick_gen
    import valve_exec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic [2:0] time_unit,
    output logic       tick
);

    localparam int unsigned P1Us   = unit_period(CLK_HZ, TimeUnit1Us);
    localparam int unsigned P1Ms   = unit_period(CLK_HZ, TimeUnit1Ms);
    localparam int unsigned P10Ms  = unit_period(CLK_HZ, TimeUnit10Ms);
    localparam int unsigned P100Ms = unit_period(CLK_HZ, TimeUnit100Ms);
    localparam int unsigned P1S    = unit_period(CLK_HZ, TimeUnit1S);

    logic [31:0] period;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        case (time_unit)
            TimeUnit1Ms:   period = P1Ms;
            TimeUnit10Ms:  period = P10Ms;
            TimeUnit100Ms: period = P100Ms;
            TimeUnit1S:    period = P1S;
            default:       period = P1Us;
        endcase
    end

    assign tick = (cnt_q == period - 32'd1);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/valve_exec.sv
// Valve instruction executor: SET / DELAY (timed or manual step) / HALT.
// Define VALVE_SAFE_HALT_EN to clear all valves when HALT is entered.
module valve_exec
    import valve_exec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ins_valid,
    input  logic [3:0]  valve,
    input  logic        set_bit,
    input  logic [9:0]  delay,
    input  logic        delay_start,
    input  logic [2:0]  time_unit,
    input  logic        pchalt,
    input  logic        debug,
    input  logic        manual_step,
    output logic [15:0] valve_out,
    output logic        busy,
    output logic        delay_done,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [9:0]  count_q, count_d;
    logic [2:0]  unit_q, unit_d;
    logic [15:0] valve_q, valve_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        step_rise;
    logic        restart;
    logic        tick;

    unit_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .time_unit(unit_q),
        .tick     (tick)
    );

    assign step_rise = sync2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unit_d  = unit_q;
        valve_d = valve_q;
        restart = 1'b0;
        case (state_q)
            StIdle: begin
                if (ins_valid) begin
                    if (pchalt) begin
                        state_d = StHalt;
`ifdef VALVE_SAFE_HALT_EN
                        valve_d = '0;
`endif
                    end else if (delay_start) begin
                        if (debug) begin
                            state_d = StManual;
                        end else begin
                            state_d = StCount;
                            count_d = delay;
                            unit_d  = time_unit;
                            restart = 1'b1;
                        end
                    end else begin
                        valve_d[valve] = set_bit;
                    end
                end
            end
            StCount: begin
                if (count_q == 10'd0) begin
                    state_d = StIdle;
                end else if (tick) begin
                    count_d = count_q - 10'd1;
                end
            end
            // A step edge reuses the zero-count COUNT cycle to emit delay_done.
            StManual: begin
                if (step_rise) begin
                    state_d = StCount;
                    count_d = '0;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == StCount) || (state_q == StManual);
        delay_done = (state_q == StCount) && (count_q == 10'd0);
        halted     = (state_q == StHalt);
    end

    assign valve_out = valve_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            unit_q  <= '0;
            valve_q <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            unit_q  <= unit_d;
            valve_q <= valve_d;
            sync1_q <= manual_step;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

endmodule

// File: tb/tb_valve_exec.sv
// Self-checking bench for valve_exec at CLK_HZ = 1 MHz (1 us = 1 cycle).
// Honours VALVE_SAFE_HALT_EN for the expected HALT valve state.
module tb_valve_exec;

    localparam int unsigned ClkHz = 1_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic [3:0]  valve;
    logic        set_bit;
    logic [9:0]  delay;
    logic        delay_start;
    logic [2:0]  time_unit;
    logic        pchalt;
    logic        debug;
    logic        manual_step;
    logic [15:0] valve_out;
    logic        busy;
    logic        delay_done;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] vmodel;

    valve_exec #(
        .CLK_HZ(ClkHz)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .valve      (valve),
        .set_bit    (set_bit),
        .delay      (delay),
        .delay_start(delay_start),
        .time_unit  (time_unit),
        .pchalt     (pchalt),
        .debug      (debug),
        .manual_step(manual_step),
        .valve_out  (valve_out),
        .busy       (busy),
        .delay_done (delay_done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Cycles per unit at 1 MHz, straight from the unit table; reserved codes mean 1 us.
    function automatic int unit_cycles(input int u);
        case (u)
            1: return 1000;
            2: return 10000;
            3: return 100000;
            4: return 1000000;
            default: return 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ins_valid   = 1'b0;
        pchalt      = 1'b0;
        delay_start = 1'b0;
        debug       = 1'b0;
    endtask

    // One-cycle SET strobe; returns at the start of the cycle after the sampling edge.
    task automatic issue_set(input int v, input bit b);
        ins_valid = 1'b1; pchalt = 1'b0; delay_start = 1'b0;
        valve = 4'(v); set_bit = b;
        step();
        ins_valid = 1'b0;
    endtask

    task automatic issue_delay(input int d, input int u, input bit dbg);
        ins_valid = 1'b1; pchalt = 1'b0; delay_start = 1'b1; debug = dbg;
        delay = 10'(d); time_unit = 3'(u);
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        valve = '0; set_bit = 1'b0; delay = '0; time_unit = '0; manual_step = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({valve_out, busy, delay_done, halted} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset outputs got vo=%h busy=%b done=%b halt=%b exp all 0",
                     valve_out, busy, delay_done, halted);
        end
        rst = 1'b0;
        vmodel = '0;
    endtask

    task automatic test_set();
        issue_set(3, 1'b1);
        vmodel[3] = 1'b1;
        n_cmp++;
        if (valve_out !== 16'h0008) begin
            n_bad++; $display("FAIL set_v3_on got %h exp 0008", valve_out);
        end
        issue_set(3, 1'b0);
        vmodel[3] = 1'b0;
        n_cmp++;
        if (valve_out !== 16'h0000) begin
            n_bad++; $display("FAIL set_v3_off got %h exp 0000", valve_out);
        end
    endtask

    task automatic test_back_to_back_sets();
        for (int i = 0; i < 24; i++) begin
            int v;
            bit b;
            v = $urandom_range(15, 0);
            b = 1'($urandom);
            issue_set(v, b);
            vmodel[v] = b;
            n_cmp++;
            if (valve_out !== vmodel || busy !== 1'b0 || delay_done !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_set[%0d] got vo=%h busy=%b done=%b exp vo=%h busy=0 done=0",
                         i, valve_out, busy, delay_done, vmodel);
            end
        end
    endtask

    // Expect delay_done exactly in cycle T+d*N+1 and busy from T+1 through that cycle.
    task automatic test_delay(input int d, input int u, input bit inject);
        int expk;
        int iv;
        expk = d * unit_cycles(u) + 1;
        iv = 0;
        issue_delay(d, u, 1'b0);
        for (int k = 1; k <= expk; k++) begin
            if (k == 3) ins_valid = 1'b0;
            n_cmp++;
            if (busy !== 1'b1 || delay_done !== (k == expk)) begin
                n_bad++;
                $display("FAIL delay d=%0d u=%0d cyc T+%0d got busy=%b done=%b exp busy=1 done=%b",
                         d, u, k, busy, delay_done, (k == expk));
            end
            if (k == 2 && inject) begin
                iv = $urandom_range(15, 0);
                ins_valid = 1'b1; delay_start = 1'b0; valve = 4'(iv);
                set_bit = ~vmodel[iv];
            end
            step();
        end
        ins_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || delay_done !== 1'b0 || valve_out !== vmodel) begin
            n_bad++;
            $display("FAIL delay_end d=%0d u=%0d got busy=%b done=%b vo=%h exp 0 0 %h",
                     d, u, busy, delay_done, valve_out, vmodel);
        end
    endtask

    task automatic test_random_delays();
        int units [4] = '{0, 5, 6, 7};
        for (int i = 0; i < 6; i++) begin
            test_delay($urandom_range(20, 0), units[$urandom_range(3, 0)], 1'($urandom));
        end
    endtask

    task automatic test_manual();
        manual_step = 1'b1;
        repeat (4) step();
        issue_delay(7, 0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (busy !== 1'b1 || delay_done !== 1'b0) begin
                n_bad++;
                $display("FAIL manual_held j=%0d got busy=%b done=%b exp 1 0", j, busy, delay_done);
            end
            step();
        end
        manual_step = 1'b0;
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (busy !== 1'b1 || delay_done !== 1'b0) begin
                n_bad++;
                $display("FAIL manual_low j=%0d got busy=%b done=%b exp 1 0", j, busy, delay_done);
            end
            step();
        end
        // Two synchronizer flops plus the edge detector: done lands three edges after the raise.
        manual_step = 1'b1;
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (busy !== (j <= 3) || delay_done !== (j == 3)) begin
                n_bad++;
                $display("FAIL manual_rise j=%0d got busy=%b done=%b exp %b %b",
                         j, busy, delay_done, (j <= 3), (j == 3));
            end
            step();
        end
        manual_step = 1'b0;
    endtask

    task automatic test_reset_abort();
        issue_set(9, 1'b1);
        vmodel[9] = 1'b1;
        issue_delay(10, 0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vmodel = '0;
        n_cmp++;
        if ({valve_out, busy, delay_done, halted} !== 19'd0) begin
            n_bad++;
            $display("FAIL abort_outputs got vo=%h busy=%b done=%b halt=%b exp all 0",
                     valve_out, busy, delay_done, halted);
        end
        for (int j = 0; j < 15; j++) begin
            n_cmp++;
            if (delay_done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_quiet j=%0d got busy=%b done=%b exp 0 0", j, busy, delay_done);
            end
            step();
        end
        issue_set(2, 1'b1);
        vmodel[2] = 1'b1;
        n_cmp++;
        if (valve_out !== vmodel) begin
            n_bad++; $display("FAIL abort_set_after got %h exp %h", valve_out, vmodel);
        end
    endtask

    task automatic test_halt();
        logic [15:0] exp_vo;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vmodel = '0;
        for (int v = 4; v < 8; v++) begin
            issue_set(v, 1'b1);
            vmodel[v] = 1'b1;
        end
        n_cmp++;
        if (valve_out !== 16'h00F0) begin
            n_bad++; $display("FAIL halt_pre got %h exp 00f0", valve_out);
        end
`ifdef VALVE_SAFE_HALT_EN
        exp_vo = 16'h0000;
`else
        exp_vo = 16'h00F0;
`endif
        // HALT with delay_start also set: HALT must win.
        ins_valid = 1'b1; pchalt = 1'b1; delay_start = 1'b1; debug = 1'b0;
        delay = 10'd3; time_unit = 3'd0;
        step();
        drive_idle();
        n_cmp++;
        if (halted !== 1'b1 || busy !== 1'b0 || valve_out !== exp_vo) begin
            n_bad++;
            $display("FAIL halt_enter got halt=%b busy=%b vo=%h exp 1 0 %h",
                     halted, busy, valve_out, exp_vo);
        end
        issue_set(0, 1'b1);
        issue_set(5, 1'b0);
        issue_delay(2, 0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (halted !== 1'b1 || busy !== 1'b0 || delay_done !== 1'b0 || valve_out !== exp_vo) begin
                n_bad++;
                $display("FAIL halt_ignore j=%0d got halt=%b busy=%b done=%b vo=%h exp 1 0 0 %h",
                         j, halted, busy, delay_done, valve_out, exp_vo);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || valve_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL halt_reset got halt=%b vo=%h exp 0 0000", halted, valve_out);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_back_to_back_sets();
        test_delay(5, 0, 1'b1);
        test_delay(0, 0, 1'b0);
        test_delay(2, 1, 1'b1);
        test_delay(4, 7, 1'b0);
        test_random_delays();
        test_manual();
        test_reset_abort();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout compared=%0d exp finish before 5ms", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
